exc_commit_ctrl: RTL
====================

Name: exc_commit_ctrl

Overview:
- Exception/interrupt commit sequencer between the WB stage and the CSR file.
- Samples WB-stage exception flags and the CSR interrupt-pending line, and selects one event by fixed priority.
- Drives the CSR exception-commit inputs for exactly one cycle, captures the handler/return target, then holds a redirect request to IF until accepted.
- Stalls WB and flushes the pipeline while a commit is in flight.

Parameters:
- PC_W, 32, PC/vaddr width.
- ECODE_W, 6, exception code width.
- ESUB_W, 9, exception subcode width.

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- wb_valid  in  1  WB holds a valid instruction this cycle
- wb_pc  in  PC_W  WB instruction PC
- wb_vaddr  in  PC_W  WB memory address (for ALE)
- wb_adef  in  1  fetch address error
- wb_ine  in  1  undefined instruction
- wb_priv  in  1  privileged instruction (csr*, ertn)
- wb_sys  in  1  syscall
- wb_brk  in  1  break
- wb_ale  in  1  misaligned access
- wb_ertn  in  1  ertn instruction
- csr_has_int  in  1  CSR interrupt pending and enabled
- csr_plv  in  2  current privilege level
- csr_ex_entry  in  PC_W  CSR target (era when ertn_flush, else eentry)
- wb_ready  out  1  WB may retire (0 while busy)
- ex_commit  out  1  to CSR wb_ex_with_ertn
- ertn_flush  out  1  to CSR ertn_flush
- ex_pc  out  PC_W  to CSR wb_pc
- ex_vaddr  out  PC_W  to CSR wb_vaddr
- ex_ecode  out  ECODE_W  to CSR wb_ecode
- ex_esubcode  out  ESUB_W  to CSR wb_esubcode
- flush  out  1  kill all younger pipeline state
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  PC_W  redirect target
- redirect_ready  in  1  IF accepts redirect

Behaviour:
- Reset: state IDLE; all outputs 0 except wb_ready=1. Reset mid-operation returns to IDLE on the next edge and drops redirect_valid without waiting for the handshake.
- Event detect (IDLE only, combinational):
  - ipe = wb_priv & (csr_plv==3).
  - Fires when wb_valid & (csr_has_int | adef | ine | ipe | sys | brk | ale | ertn).
- Priority, highest first, with ecode/esubcode:
  - INT 0x00/0
  - ADEF 0x08/0
  - INE 0x0D/0
  - IPE 0x0E/0
  - SYS 0x0B/0
  - BRK 0x0C/0
  - ALE 0x09/0
  - ERTN: no ecode.
  - ERTN is taken only when no other flag is set; a higher-priority flag suppresses it.
- Normal retire: in IDLE with no event, wb_ready=1 and no other output is active.
- FSM states IDLE, COMMIT, REDIRECT:
  - IDLE → COMMIT on event.
    - On that edge, register ex_pc=wb_pc, ex_vaddr=wb_vaddr, ecode, esubcode, and is_ertn.
    - wb_ready=0 combinationally in the detect cycle, so the faulting instruction does not retire its GPR write.
  - COMMIT lasts exactly 1 cycle.
    - ex_commit=1; ertn_flush=is_ertn; flush=1.
    - Capture redirect_pc=csr_ex_entry on the exit edge.
    - → REDIRECT.
  - REDIRECT:
    - redirect_valid=1 and flush=1; redirect_pc stable.
    - → IDLE on the edge where redirect_ready=1.
    - redirect_ready already high on entry gives a minimum 1-cycle REDIRECT.
- Latency: detect at cycle N → ex_commit at N+1 → redirect_valid from N+2 → earliest return to IDLE at end of N+2. wb_ready is 0 from N through the last REDIRECT cycle.
- In COMMIT/REDIRECT all wb_* and csr_has_int inputs are ignored. csr_has_int rising during REDIRECT is taken on the first valid WB instruction after IDLE.
- An interrupt with wb_valid=0 is not taken; wait for a valid instruction.
- ex_commit and ertn_flush are never high outside COMMIT. They pulse exactly once per event.
- ex_pc/ex_vaddr/ex_ecode/ex_esubcode hold their last value after COMMIT.

Decomposition:
- Shared constants header: ECODE_INT/ADE/ALE/SYS/BRK/INE/IPE, ESUBCODE_ADEF, FSM state encodings (2-bit).
- One sub-module, exc_prio_enc: combinational priority encoder from flags to {take, is_ertn, ecode, esubcode}. Reused by future TLB-exception extension.

Test Plan:
- wb_valid=1, wb_sys=1, wb_pc=0x1c000100 → N+1 ex_commit=1, ecode=0x0B, ex_pc=0x1c000100; csr_ex_entry=0x1c008000 gives redirect_pc=0x1c008000; redirect_ready=1 at N+2 → IDLE at N+3; wb_ready=0 at N..N+2.
- wb_ertn=1, csr_ex_entry=0x1c000204 → ex_commit=1 and ertn_flush=1 same cycle, redirect_pc=0x1c000204.
- wb_adef=1, wb_ine=1, wb_ale=1, csr_has_int=1 → ecode=0x00. Repeat without int → ecode=0x08, esub=0. Then ine+ale only → ecode=0x0D.
- wb_priv=1, csr_plv=3 → ecode=0x0E; same with csr_plv=0 → no event, wb_ready=1.
- Hold redirect_ready=0 for 5 cycles → redirect_valid and redirect_pc stable, flush=1; a new wb_brk pulse is ignored; single ex_commit pulse total.
- Assert reset in REDIRECT → next cycle IDLE, redirect_valid=0, flush=0, wb_ready=1.

Source files
------------

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared constants and types for the exception commit sequencer.
// Exception codes match the CSR estat.ecode field.
package exc_commit_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [5:0] ECODE_IPE = 6'h0E;

    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    typedef struct packed {
        logic intr;
        logic adef;
        logic ine;
        logic ipe;
        logic sys;
        logic brk;
        logic ale;
        logic ertn;
    } exc_flags_t;

    typedef struct packed {
        logic       take;
        logic       is_ertn;
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } exc_sel_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// Redirect handshake from the commit sequencer to IF.
// The master raises redirect_valid and holds redirect_pc until ready.
interface exc_commit_ctrl_if #(
    parameter int PC_W = 32
);
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready
    );

    modport slave (
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: flags in, selected event out.
// ERTN wins only when no real exception or interrupt is present.
module exc_prio_enc
    import exc_commit_ctrl_pkg::*;
(
    input  exc_flags_t flags,
    output exc_sel_t   sel
);

    always_comb begin
        sel      = '0;
        sel.take = |flags;
        priority case (1'b1)
            flags.intr: sel.ecode = ECODE_INT;
            flags.adef: begin
                sel.ecode    = ECODE_ADE;
                sel.esubcode = ESUBCODE_ADEF;
            end
            flags.ine:  sel.ecode = ECODE_INE;
            flags.ipe:  sel.ecode = ECODE_IPE;
            flags.sys:  sel.ecode = ECODE_SYS;
            flags.brk:  sel.ecode = ECODE_BRK;
            flags.ale:  sel.ecode = ECODE_ALE;
            flags.ertn: sel.is_ertn = 1'b1;
            default:    sel = '0;
        endcase
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit sequencer between WB and the CSR file.
// IDLE detects, COMMIT pulses the CSR update, REDIRECT holds IF redirect.
module exc_commit_ctrl
    import exc_commit_ctrl_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ECODE_W = 6,
    parameter int ESUB_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_valid,
    input  logic [PC_W-1:0]    wb_pc,
    input  logic [PC_W-1:0]    wb_vaddr,
    input  logic               wb_adef,
    input  logic               wb_ine,
    input  logic               wb_priv,
    input  logic               wb_sys,
    input  logic               wb_brk,
    input  logic               wb_ale,
    input  logic               wb_ertn,
    input  logic               csr_has_int,
    input  logic [1:0]         csr_plv,
    input  logic [PC_W-1:0]    csr_ex_entry,
    output logic               wb_ready,
    output logic               ex_commit,
    output logic               ertn_flush,
    output logic [PC_W-1:0]    ex_pc,
    output logic [PC_W-1:0]    ex_vaddr,
    output logic [ECODE_W-1:0] ex_ecode,
    output logic [ESUB_W-1:0]  ex_esubcode,
    output logic               flush,
    exc_commit_ctrl_if.master  redirect
);

    state_t     state;
    state_t     state_nxt;
    exc_flags_t flags;
    exc_sel_t   sel;
    logic       take;
    logic       is_ertn;

    assign flags.intr = csr_has_int;
    assign flags.adef = wb_adef;
    assign flags.ine  = wb_ine;
    assign flags.ipe  = wb_priv & (csr_plv == 2'd3);
    assign flags.sys  = wb_sys;
    assign flags.brk  = wb_brk;
    assign flags.ale  = wb_ale;
    assign flags.ertn = wb_ertn;

    exc_prio_enc u_prio_enc (
        .flags (flags),
        .sel   (sel)
    );

    // Only meaningful in IDLE; other states ignore WB entirely.
    assign take = wb_valid & sel.take;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (take) state_nxt = ST_COMMIT;
            ST_COMMIT:   state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redirect.redirect_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_ready                = 1'b0;
        ex_commit               = 1'b0;
        ertn_flush              = 1'b0;
        flush                   = 1'b0;
        redirect.redirect_valid = 1'b0;
        unique case (state)
            ST_IDLE: wb_ready = ~take;
            ST_COMMIT: begin
                ex_commit  = 1'b1;
                ertn_flush = is_ertn;
                flush      = 1'b1;
            end
            ST_REDIRECT: begin
                flush                   = 1'b1;
                redirect.redirect_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Event record is captured on entry to COMMIT and held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_pc                <= '0;
            ex_vaddr             <= '0;
            ex_ecode             <= '0;
            ex_esubcode          <= '0;
            is_ertn              <= 1'b0;
            redirect.redirect_pc <= '0;
        end else begin
            if (state == ST_IDLE && take) begin
                ex_pc       <= wb_pc;
                ex_vaddr    <= wb_vaddr;
                ex_ecode    <= ECODE_W'(sel.ecode);
                ex_esubcode <= ESUB_W'(sel.esubcode);
                is_ertn     <= sel.is_ertn;
            end
            if (state == ST_COMMIT) begin
                redirect.redirect_pc <= csr_ex_entry;
            end
        end
    end

endmodule
